// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC generator with redirect priority and an optional return-address stack.
// Define PC_SEQ_RAS_EN to build the RAS; without it call_push/ret_pop are ignored.
module pc_sequencer #(
  parameter int unsigned         PC_WIDTH      = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [PC_WIDTH-1:0] IDLE_PC       = PC_WIDTH'(4),
  parameter logic [PC_WIDTH-1:0] PC_INC        = PC_WIDTH'(4),
  parameter logic [PC_WIDTH-1:0] TARGET_OFFSET = PC_WIDTH'(4),
  parameter int unsigned         RAS_DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        work_ena,
  input  logic                        stall,
  input  logic                        fetch_ready,
  input  logic                        exc_valid,
  input  logic [PC_WIDTH-1:0]         exc_target,
  input  logic                        pc_jump,
  input  logic [PC_WIDTH-1:0]         pc_target,
  input  logic                        call_push,
  input  logic                        ret_pop,
  output logic [PC_WIDTH-1:0]         pc,
  output logic                        pc_valid,
  output logic                        pc_redirect,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_underflow
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e state_q, state_d;

  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_seq, ras_top;
  logic                redirect_q, redirect_d;
  logic                underflow_q, underflow_d;
  logic                advance, pop_hit;

  // Handshake: pc is offered while pc_valid=1 and is consumed on a cycle with
  // fetch_ready=1 and stall=0; otherwise pc holds unless a redirect overrides it.
  assign pc_seq  = pc_q + PC_INC;
  assign advance = work_ena && !exc_valid && !pc_jump && !stall && fetch_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (work_ena)  state_d = S_RUN;
      S_RUN:   if (!work_ena) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // pc_valid is a direct decode of the state register, so it doubles as the state probe.
  always_comb begin
    pc_valid = (state_q == S_RUN);
  end

`ifdef PC_SEQ_RAS_EN
  localparam int unsigned SPW = $clog2(RAS_DEPTH);
  localparam int unsigned CW  = SPW + 1;

  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [SPW-1:0]      sp_q, sp_d, top_idx, wr_idx;
  logic [CW-1:0]       count_q, count_d;
  logic                wr_en;

  // sp_q is the next free slot; it wraps so a push on a full stack overwrites the oldest entry.
  assign top_idx = sp_q - SPW'(1);
  assign ras_top = ras_q[top_idx];
  assign pop_hit = advance && ret_pop && (count_q != '0);

  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    wr_en       = 1'b0;
    wr_idx      = sp_q;
    underflow_d = 1'b0;
    if (work_ena && exc_valid) begin
      count_d = '0;
    end else if (advance) begin
      if (pop_hit) begin
        if (call_push) begin
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else begin
          sp_d    = top_idx;
          count_d = count_q - CW'(1);
        end
      end else begin
        underflow_d = ret_pop;
        if (call_push) begin
          wr_en = 1'b1;
          sp_d  = sp_q + SPW'(1);
          if (count_q != CW'(RAS_DEPTH)) begin
            count_d = count_q + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= '0;
      count_q <= '0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
    end
    if (wr_en && !rst) begin
      ras_q[wr_idx] <= pc_seq;
    end
  end

  assign ras_count = count_q;
`else
  logic unused_ras;
  assign unused_ras  = call_push ^ ret_pop;
  assign pop_hit     = 1'b0;
  assign ras_top     = '0;
  assign underflow_d = 1'b0;
  assign ras_count   = '0;
`endif

  always_comb begin
    pc_d       = pc_q;
    redirect_d = 1'b0;
    if (!work_ena) begin
      pc_d = IDLE_PC;
    end else if (exc_valid) begin
      pc_d       = exc_target;
      redirect_d = 1'b1;
    end else if (pc_jump) begin
      pc_d       = pc_target + TARGET_OFFSET;
      redirect_d = 1'b1;
    end else if (advance) begin
      if (pop_hit) begin
        pc_d       = ras_top;
        redirect_d = 1'b1;
      end else begin
        pc_d = pc_seq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      redirect_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      redirect_q  <= redirect_d;
      underflow_q <= underflow_d;
    end
  end

  assign pc            = pc_q;
  assign pc_redirect   = redirect_q;
  assign ras_underflow = underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer; expectations adapt to whether PC_SEQ_RAS_EN is defined.
module tb_pc_sequencer;

  localparam int CW = 3;
  localparam int OW = 32 + 2 + CW + 1;
`ifdef PC_SEQ_RAS_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif

  typedef logic [OW-1:0] obs_t;

  typedef struct {
    string       name;
    logic        rst, wena, stall, frdy, exc, jmp, push, pop;
    logic [31:0] exc_t, jmp_t;
    logic [31:0] e_pc;
    logic        e_valid, e_redir, e_uf;
    logic [CW-1:0] e_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, work_ena, stall, fetch_ready, exc_valid, pc_jump, call_push, ret_pop;
  logic [31:0] exc_target, pc_target;
  logic [31:0] pc;
  logic        pc_valid, pc_redirect, ras_underflow;
  logic [CW-1:0] ras_count;
  logic [7:0]  pc8;
  logic        pc_valid8, pc_redirect8, ras_underflow8;
  logic [CW-1:0] ras_count8;

  vec_t vecs[$];
  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .PC_WIDTH(32), .RESET_PC(32'h0), .IDLE_PC(32'h4), .PC_INC(32'h4),
    .TARGET_OFFSET(32'h4), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .work_ena(work_ena), .stall(stall), .fetch_ready(fetch_ready),
    .exc_valid(exc_valid), .exc_target(exc_target), .pc_jump(pc_jump), .pc_target(pc_target),
    .call_push(call_push), .ret_pop(ret_pop), .pc(pc), .pc_valid(pc_valid),
    .pc_redirect(pc_redirect), .ras_count(ras_count), .ras_underflow(ras_underflow)
  );

  pc_sequencer #(
    .PC_WIDTH(8), .RESET_PC(8'h0), .IDLE_PC(8'h4), .PC_INC(8'h4),
    .TARGET_OFFSET(8'h4), .RAS_DEPTH(4)
  ) dut8 (
    .clk(clk), .rst(rst), .work_ena(work_ena), .stall(stall), .fetch_ready(fetch_ready),
    .exc_valid(exc_valid), .exc_target(exc_target[7:0]), .pc_jump(pc_jump),
    .pc_target(pc_target[7:0]), .call_push(call_push), .ret_pop(ret_pop), .pc(pc8),
    .pc_valid(pc_valid8), .pc_redirect(pc_redirect8), .ras_count(ras_count8),
    .ras_underflow(ras_underflow8)
  );

  function automatic vec_t mk(input string n, input logic r, w, s, f, e, input logic [31:0] et,
                              input logic j, input logic [31:0] jt, input logic cp, rp,
                              input logic [31:0] epc, input logic ev, er, input int ec,
                              input logic eu);
    vec_t v;
    v.name = n; v.rst = r; v.wena = w; v.stall = s; v.frdy = f;
    v.exc = e; v.exc_t = et; v.jmp = j; v.jmp_t = jt; v.push = cp; v.pop = rp;
    v.e_pc = epc; v.e_valid = ev; v.e_redir = er; v.e_cnt = CW'(ec); v.e_uf = eu;
    return v;
  endfunction

  task automatic add(input string n, input logic r, w, s, f, e, input logic [31:0] et,
                     input logic j, input logic [31:0] jt, input logic cp, rp,
                     input logic [31:0] epc, input logic ev, er, input int ec, input logic eu);
    vecs.push_back(mk(n, r, w, s, f, e, et, j, jt, cp, rp, epc, ev, er, ec, eu));
  endtask

  task automatic check(input string n);
    obs_t act, exp;
    act = {pc, pc_valid, pc_redirect, ras_count, ras_underflow};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty, actual pc=%h", n, pc);
      return;
    end
    exp = exp_q.pop_front();
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual pc=%h valid=%b redir=%b cnt=%0d uf=%b, required pc=%h valid=%b redir=%b cnt=%0d uf=%b",
               n, pc, pc_valid, pc_redirect, ras_count, ras_underflow,
               exp[OW-1 -: 32], exp[CW+2], exp[CW+1], exp[CW:1], exp[0]);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; work_ena = v.wena; stall = v.stall; fetch_ready = v.frdy;
    exc_valid = v.exc; exc_target = v.exc_t; pc_jump = v.jmp; pc_target = v.jmp_t;
    call_push = v.push; ret_pop = v.pop;
    exp_q.push_back({v.e_pc, v.e_valid, v.e_redir, v.e_cnt, v.e_uf});
    @(posedge clk);
    #1;
    check(v.name);
  endtask

  task automatic check8(input string n, input logic [13:0] expv);
    logic [13:0] act;
    act = {pc8, pc_valid8, pc_redirect8, ras_count8, ras_underflow8};
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: actual pc8=%h v=%b r=%b cnt=%0d uf=%b, required pc8=%h v=%b r=%b cnt=%0d uf=%b",
               n, act[13:6], act[5], act[4], act[3:1], act[0],
               expv[13:6], expv[5], expv[4], expv[3:1], expv[0]);
    end
  endtask

  initial begin
    logic [31:0] mpc;
    logic        s, f;

    rst = 1'b1; work_ena = 1'b0; stall = 1'b0; fetch_ready = 1'b1; exc_valid = 1'b0;
    exc_target = '0; pc_jump = 1'b0; pc_target = '0; call_push = 1'b0; ret_pop = 1'b0;

    //   name         rst wen stl frd exc exc_t    jmp jmp_t   psh pop exp_pc   v  r  cnt uf
    add("rst",         1, 0, 0, 1, 0, 0,        0, 0,       0, 0, 32'h0,   0, 0, 0, 0);
    add("idle_a",      0, 0, 0, 1, 0, 0,        0, 0,       0, 0, 32'h4,   0, 0, 0, 0);
    add("idle_b",      0, 0, 0, 1, 0, 0,        0, 0,       0, 0, 32'h4,   0, 0, 0, 0);
    add("en_a",        0, 1, 0, 1, 0, 0,        0, 0,       0, 0, 32'h8,   1, 0, 0, 0);
    add("en_b",        0, 1, 0, 1, 0, 0,        0, 0,       0, 0, 32'hC,   1, 0, 0, 0);
    add("jmp_1c",      0, 1, 0, 1, 0, 0,        1, 32'h18,  0, 0, 32'h1C,  1, 1, 0, 0);
    add("push_20",     0, 1, 0, 1, 0, 0,        0, 0,       1, 0, 32'h20,  1, 0, R, 0);
    add("exc_prio",    0, 1, 1, 1, 1, 32'h100,  1, 32'h200, 1, 1, 32'h100, 1, 1, 0, 0);
    add("after_exc",   0, 1, 0, 1, 0, 0,        0, 0,       0, 0, 32'h104, 1, 0, 0, 0);
    add("pop_cleared", 0, 1, 0, 1, 0, 0,        0, 0,       0, 1, 32'h108, 1, 0, 0, R);
    add("jmp_40",      0, 1, 0, 1, 0, 0,        1, 32'h3C,  0, 0, 32'h40,  1, 1, 0, 0);
    add("jmp_stall",   0, 1, 1, 1, 0, 0,        1, 32'h80,  0, 0, 32'h84,  1, 1, 0, 0);
    add("stall_hold",  0, 1, 1, 1, 0, 0,        0, 0,       0, 0, 32'h84,  1, 0, 0, 0);
    add("frdy_hold",   0, 1, 0, 0, 0, 0,        0, 0,       1, 1, 32'h84,  1, 0, 0, 0);
    add("adv_88",      0, 1, 0, 1, 0, 0,        0, 0,       0, 0, 32'h88,  1, 0, 0, 0);
    add("jmp_10",      0, 1, 0, 1, 0, 0,        1, 32'hC,   0, 0, 32'h10,  1, 1, 0, 0);
    add("call_10",     0, 1, 0, 1, 0, 0,        0, 0,       1, 0, 32'h14,  1, 0, R, 0);
    add("jmp_30",      0, 1, 0, 1, 0, 0,        1, 32'h2C,  0, 0, 32'h30,  1, 1, R, 0);
    add("call_30",     0, 1, 0, 1, 0, 0,        0, 0,       1, 0, 32'h34,  1, 0, 2*R, 0);
    add("ret_a",       0, 1, 0, 1, 0, 0,        0, 0,       0, 1, R ? 32'h34 : 32'h38, 1, R, R, 0);
    add("ret_b",       0, 1, 0, 1, 0, 0,        0, 0,       0, 1, R ? 32'h14 : 32'h3C, 1, R, 0, 0);
    add("ret_uf",      0, 1, 0, 1, 0, 0,        0, 0,       0, 1, R ? 32'h18 : 32'h40, 1, 0, 0, R);
    add("jmp_200",     0, 1, 0, 1, 0, 0,        1, 32'h1FC, 0, 0, 32'h200, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      add($sformatf("ovf_push%0d", i), 0, 1, 0, 1, 0, 0, 0, 0, 1, 0,
          32'h204 + 32'(4 * i), 1, 0, R * ((i + 1 > 4) ? 4 : i + 1), 0);
    for (int i = 0; i < 4; i++)
      add($sformatf("ovf_pop%0d", i), 0, 1, 0, 1, 0, 0, 0, 0, 0, 1,
          R ? 32'h214 - 32'(4 * i) : 32'h218 + 32'(4 * i), 1, R, R * (3 - i), 0);
    add("ovf_pop_uf",  0, 1, 0, 1, 0, 0,        0, 0,       0, 1, R ? 32'h20C : 32'h228, 1, 0, 0, R);
    add("jmp_300",     0, 1, 0, 1, 0, 0,        1, 32'h2FC, 0, 0, 32'h300, 1, 1, 0, 0);
    add("sim_push",    0, 1, 0, 1, 0, 0,        0, 0,       1, 0, 32'h304, 1, 0, R, 0);
    add("sim_adv",     0, 1, 0, 1, 0, 0,        0, 0,       0, 0, 32'h308, 1, 0, R, 0);
    add("sim_pp",      0, 1, 0, 1, 0, 0,        0, 0,       1, 1, R ? 32'h304 : 32'h30C, 1, R, R, 0);
    add("sim_pop",     0, 1, 0, 1, 0, 0,        0, 0,       0, 1, R ? 32'h30C : 32'h310, 1, R, 0, 0);
    add("sim_pp_empty",0, 1, 0, 1, 0, 0,        0, 0,       1, 1, R ? 32'h310 : 32'h314, 1, 0, R, R);
    add("sim_pop2",    0, 1, 0, 1, 0, 0,        0, 0,       0, 1, R ? 32'h310 : 32'h318, 1, R, 0, 0);
    add("pre_rst_push",0, 1, 0, 1, 0, 0,        0, 0,       1, 0, R ? 32'h314 : 32'h31C, 1, 0, R, 0);
    add("stall_push",  0, 1, 1, 1, 0, 0,        0, 0,       1, 0, R ? 32'h314 : 32'h31C, 1, 0, R, 0);
    add("rst_mid",     1, 1, 1, 1, 1, 32'h500,  1, 32'h600, 1, 1, 32'h0,   0, 0, 0, 0);
    add("post_rst",    0, 1, 0, 1, 0, 0,        0, 0,       0, 0, 32'h4,   1, 0, 0, 0);
    add("idle_exc",    0, 0, 0, 1, 1, 32'h700,  1, 32'h800, 0, 0, 32'h4,   0, 0, 0, 0);
    add("resume",      0, 1, 0, 1, 0, 0,        0, 0,       0, 0, 32'h8,   1, 0, 0, 0);
    add("wrap_jmp",    0, 1, 0, 1, 0, 0,        1, 32'hFFFFFFF8, 0, 0, 32'hFFFFFFFC, 1, 1, 0, 0);
    add("wrap_adv",    0, 1, 0, 1, 0, 0,        0, 0,       0, 0, 32'h0,   1, 0, 0, 0);

    foreach (vecs[i]) apply(vecs[i]);

    // 8-bit instance: pc 0xFC must wrap to 0x00 on increment.
    apply(mk("w8_rst", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
    apply(mk("w8_jmp", 0, 1, 0, 1, 0, 0, 1, 32'h1F8, 0, 0, 32'h1FC, 1, 1, 0, 0));
    check8("w8_fc", {8'hFC, 1'b1, 1'b1, 3'd0, 1'b0});
    apply(mk("w8_adv", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h200, 1, 0, 0, 0));
    check8("w8_00", {8'h00, 1'b1, 1'b0, 3'd0, 1'b0});

    // Random hold/advance traffic against a simple increment model.
    mpc = 32'h200;
    for (int i = 0; i < 24; i++) begin
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 3) != 0);
      if (!s && f) mpc = mpc + 32'h4;
      apply(mk($sformatf("rand%0d", i), 0, 1, s, f, 0, 0, 0, 0, 0, 0, mpc, 1, 0, 0, 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32: width of all PC/target buses.
REQ-002 SHALL have parameter RESET_PC, default 0: PC value loaded by rst.
REQ-003 SHALL have parameter IDLE_PC, default 4: PC value held while work_ena is low.
REQ-004 SHALL have parameter PC_INC, default 4: sequential increment.
REQ-005 SHALL have parameter TARGET_OFFSET, default 4: added to pc_target on a jump.
REQ-006 SHALL have parameter RAS_DEPTH, default 4 (power of two, >=2): return-address-stack entries.
REQ-007 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-008 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-009 SHALL have port work_ena  in  1  core enable; low forces idle.
REQ-010 SHALL have port stall  in  1  pipeline hold request.
REQ-011 SHALL have port fetch_ready  in  1  fetch stage accepts the current pc.
REQ-012 SHALL have port exc_valid  in  1  exception/trap redirect request.
REQ-013 SHALL have port exc_target  in  PC_WIDTH  exception vector.
REQ-014 SHALL have port pc_jump  in  1  resolved jump/branch redirect.
REQ-015 SHALL have port pc_target  in  PC_WIDTH  jump target.
REQ-016 SHALL have port call_push  in  1  current pc is a call; push return address.
REQ-017 SHALL have port ret_pop  in  1  current pc is a return; predict from RAS.
REQ-018 SHALL have port pc  out  PC_WIDTH  current fetch PC.
REQ-019 SHALL have port pc_valid  out  1  pc is a valid fetch address.
REQ-020 SHALL have port pc_redirect  out  1  one-cycle pulse: pc was loaded by a redirect (exc, jump or RAS pop).
REQ-021 SHALL have port ras_count  out  $clog2(RAS_DEPTH)+1  live RAS entries.
REQ-022 SHALL have port ras_underflow  out  1  one-cycle pulse: pop on empty RAS.

Function
REQ-023 SHALL implement FSM states IDLE (pc_valid=0) and RUN (pc_valid=1); IDLE->RUN when work_ena=1, RUN->IDLE when work_ena=0.
REQ-024 SHALL apply next-pc priority per cycle: rst > !work_ena > exc_valid > pc_jump > hold > ret_pop > increment.
REQ-025 SHALL, when work_ena=0, load pc=IDLE_PC regardless of other inputs.
REQ-026 SHALL, on exc_valid, load pc=exc_target, clear ras_count to 0, pulse pc_redirect; stall and fetch_ready are ignored.
REQ-027 SHALL, on pc_jump (no exc_valid), load pc=pc_target+TARGET_OFFSET, pulse pc_redirect, leave RAS unchanged; stall is ignored.
REQ-028 SHALL hold pc, RAS and ras_count when stall=1 or fetch_ready=0 with no redirect; call_push/ret_pop ignored in that cycle.
REQ-029 SHALL, when advancing (RUN, no redirect, no hold), load pc=RAS top on ret_pop with ras_count>0 (pulse pc_redirect), else pc=pc+PC_INC.
REQ-030 SHALL, on call_push while advancing, push pc+PC_INC; on full RAS overwrite the oldest entry (circular), ras_count saturating at RAS_DEPTH.
REQ-031 SHALL, on ret_pop with ras_count=0 while advancing, pulse ras_underflow and load pc=pc+PC_INC.
REQ-032 SHALL, on simultaneous call_push and ret_pop while advancing, load pc=old top and replace top with pc+PC_INC, ras_count unchanged; if empty, treat as push plus underflow.
REQ-033 SHALL compute all PC arithmetic modulo 2^PC_WIDTH (wrap, no saturation).

Reset
REQ-034 SHALL on rst=1 set pc=RESET_PC, pc_valid=0, pc_redirect=0, ras_underflow=0, ras_count=0, state=IDLE, overriding all inputs; RAS entry contents are don't-care.
REQ-035 SHALL, when rst asserts mid-stall or mid-redirect, discard the pending operation with no residual effect after release.

Configuration
REQ-036 SHALL, with macro PC_SEQ_RAS_EN defined, implement the RAS per REQ-029..REQ-032.
REQ-037 SHALL, without PC_SEQ_RAS_EN, ignore call_push and ret_pop, tie ras_count and ras_underflow to 0, instantiate no RAS storage, and advance pc+PC_INC only.

Verification
REQ-038 SHALL test reset/enable: rst 1 cycle, work_ena=0 2 cycles, then 1 -> pc 0, 4, 4, 8, 12; pc_valid 0,0,0,1,1.
REQ-039 SHALL test priority: pc=0x20, exc_valid=1 exc_target=0x100 with pc_jump=1 pc_target=0x200 and stall=1 -> pc=0x100, pc_redirect=1, ras_count=0.
REQ-040 SHALL test jump under stall: pc=0x40, stall=1, pc_jump=1 pc_target=0x80 -> pc=0x84; next cycle stall=1 -> pc stays 0x84.
REQ-041 SHALL test RAS (PC_SEQ_RAS_EN): call_push at pc=0x10 then 0x30, ret_pop twice -> pc 0x34 then 0x14, ras_count 2,1,0; third pop -> ras_underflow=1, pc=pc+4.
REQ-042 SHALL test RAS overflow/wrap: RAS_DEPTH=4, 5 pushes -> ras_count=4, pops return last 4 return addresses, 5th pop underflows; PC_WIDTH=8 pc=0xFC increment -> 0x00.
